// File: rtl/dunc16_pkg.sv
// Shared encodings for the dunc16 control sequencer: opcodes, ALU operations,
// mux selects and the sequencing state enum.
package dunc16_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_BAN = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_BAZ = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;

  localparam logic SEL_PC_INC = 1'b0;
  localparam logic SEL_PC_MD  = 1'b1;
  localparam logic SEL_MA_PC  = 1'b0;
  localparam logic SEL_MA_MD  = 1'b1;
  localparam logic SEL_MD_MEM = 1'b0;
  localparam logic SEL_MD_AC  = 1'b1;

  // Phase x T-index, plus the terminal halt state.
  typedef enum logic [3:0] {
    ST_FT0  = 4'd0,
    ST_FT1  = 4'd1,
    ST_FT2  = 4'd2,
    ST_FT3  = 4'd3,
    ST_ET0  = 4'd4,
    ST_ET1  = 4'd5,
    ST_ET2  = 4'd6,
    ST_ET3  = 4'd7,
    ST_HALT = 4'd8
  } state_t;

endpackage

// File: rtl/dunc16_if.sv
// Control bus between the dunc16 sequencer (master) and the datapath (slave).
interface dunc16_if;
  import dunc16_pkg::*;

  logic [OPCODE_W-1:0] IR;
  logic                AZ;
  logic                AN;
  logic                MEM_RDY;
  logic                EN_PC;
  logic                EN_MA;
  logic                EN_MD;
  logic                EN_AC;
  logic                EN_IR;
  logic                SEL_PC;
  logic                SEL_MA;
  logic                SEL_MD;
  logic [1:0]          ALU_OP;
  logic                MEM_RD;
  logic                MEM_WR;

  modport master (
    input  IR, AZ, AN, MEM_RDY,
    output EN_PC, EN_MA, EN_MD, EN_AC, EN_IR,
    output SEL_PC, SEL_MA, SEL_MD, ALU_OP, MEM_RD, MEM_WR
  );

  modport slave (
    output IR, AZ, AN, MEM_RDY,
    input  EN_PC, EN_MA, EN_MD, EN_AC, EN_IR,
    input  SEL_PC, SEL_MA, SEL_MD, ALU_OP, MEM_RD, MEM_WR
  );

endinterface

// File: rtl/dunc16_tgen.sv
// T0-T3 timing ring with FETCH/EXECUTE phase; holds on stall, parks in HALT
// when halt is raised in EXECUTE T0 until the next reset.
module dunc16_tgen
  import dunc16_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic stall,
  input  logic halt,
  output logic T0,
  output logic T1,
  output logic T2,
  output logic T3,
  output logic FETCH,
  output logic EXECUTE,
  output logic HALTED
);

  state_t state, state_nxt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_FT0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    T0        = 1'b0;
    T1        = 1'b0;
    T2        = 1'b0;
    T3        = 1'b0;
    FETCH     = 1'b0;
    EXECUTE   = 1'b0;
    HALTED    = 1'b0;
    case (state)
      ST_FT0: begin T0 = 1'b1; FETCH = 1'b1; state_nxt = ST_FT1; end
      ST_FT1: begin
        T1 = 1'b1; FETCH = 1'b1;
        if (!stall) state_nxt = ST_FT2;
      end
      ST_FT2: begin T2 = 1'b1; FETCH = 1'b1; state_nxt = ST_FT3; end
      ST_FT3: begin T3 = 1'b1; FETCH = 1'b1; state_nxt = ST_ET0; end
      ST_ET0: begin
        T0 = 1'b1; EXECUTE = 1'b1;
        state_nxt = halt ? ST_HALT : ST_ET1;
      end
      ST_ET1: begin
        T1 = 1'b1; EXECUTE = 1'b1;
        if (!stall) state_nxt = ST_ET2;
      end
      ST_ET2: begin
        T2 = 1'b1; EXECUTE = 1'b1;
        if (!stall) state_nxt = ST_ET3;
      end
      ST_ET3:  begin T3 = 1'b1; EXECUTE = 1'b1; state_nxt = ST_FT0; end
      ST_HALT: HALTED = 1'b1;
      default: state_nxt = ST_FT0;
    endcase
  end

endmodule

// File: rtl/dunc16_ctrl.sv
// dunc16 control sequencer: opcode decode and memory handshake around the
// timing generator. All strobes are combinational from state, IR, flags, MEM_RDY.
module dunc16_ctrl
  import dunc16_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic           CLK,
  input  logic           RESET,
  dunc16_if.master       bus,
  output logic           T0,
  output logic           T1,
  output logic           T2,
  output logic           T3,
  output logic           FETCH,
  output logic           EXECUTE,
  output logic           HALTED
);

  generate
    if (ADDR_W < 1) begin : g_bad_addr_w
      $error("dunc16_ctrl: ADDR_W must be positive");
    end
  endgenerate

  logic stall;
  logic halt;
  logic rd_op;
  logic wr_op;
  logic mem_op;
  logic take_pc;

  dunc16_tgen u_tgen (
    .CLK     (CLK),
    .RESET   (RESET),
    .stall   (stall),
    .halt    (halt),
    .T0      (T0),
    .T1      (T1),
    .T2      (T2),
    .T3      (T3),
    .FETCH   (FETCH),
    .EXECUTE (EXECUTE),
    .HALTED  (HALTED)
  );

  assign rd_op   = (bus.IR == OP_LDA) || (bus.IR == OP_ADD) || (bus.IR == OP_AND);
  assign wr_op   = (bus.IR == OP_STA);
  assign mem_op  = rd_op || wr_op;
  // Flags are only looked at here, in EXECUTE T0, before AC can change.
  assign take_pc = (bus.IR == OP_JMP) ||
                   ((bus.IR == OP_BAN) && bus.AN) ||
                   ((bus.IR == OP_BAZ) && bus.AZ);

  always_comb begin
    bus.EN_PC  = 1'b0;
    bus.EN_MA  = 1'b0;
    bus.EN_MD  = 1'b0;
    bus.EN_AC  = 1'b0;
    bus.EN_IR  = 1'b0;
    bus.SEL_PC = SEL_PC_INC;
    bus.SEL_MA = SEL_MA_PC;
    bus.SEL_MD = SEL_MD_MEM;
    bus.ALU_OP = ALU_PASS;
    bus.MEM_RD = 1'b0;
    bus.MEM_WR = 1'b0;
    stall      = 1'b0;
    halt       = 1'b0;

    if (FETCH) begin
      if (T0) begin
        bus.EN_MA = 1'b1;
      end
      if (T1) begin
        bus.MEM_RD = 1'b1;
        if (bus.MEM_RDY) bus.EN_MD = 1'b1;
        else             stall     = 1'b1;
      end
      if (T2) begin
        bus.EN_IR = 1'b1;
        bus.EN_PC = 1'b1;
      end
    end

    if (EXECUTE) begin
      if (T0) begin
        if (mem_op) begin
          bus.EN_MA  = 1'b1;
          bus.SEL_MA = SEL_MA_MD;
        end else if (take_pc) begin
          bus.EN_PC  = 1'b1;
          bus.SEL_PC = SEL_PC_MD;
        end else if (bus.IR == OP_HLT) begin
          halt = 1'b1;
        end
      end
      if (T1) begin
        if (rd_op) begin
          bus.MEM_RD = 1'b1;
          if (bus.MEM_RDY) bus.EN_MD = 1'b1;
          else             stall     = 1'b1;
        end else if (wr_op) begin
          bus.EN_MD  = 1'b1;
          bus.SEL_MD = SEL_MD_AC;
        end
      end
      // Write strobe stays up until memory accepts it.
      if (T2) begin
        case (bus.IR)
          OP_LDA: begin bus.EN_AC = 1'b1; bus.ALU_OP = ALU_PASS; end
          OP_ADD: begin bus.EN_AC = 1'b1; bus.ALU_OP = ALU_ADD;  end
          OP_AND: begin bus.EN_AC = 1'b1; bus.ALU_OP = ALU_AND;  end
          OP_STA: begin
            bus.MEM_WR = 1'b1;
            stall      = !bus.MEM_RDY;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dunc16_ctrl.sv
// Directed bench for dunc16_ctrl: an instruction-position model predicts every
// output each cycle, and literal expectations pin cycle counts and strobe events.
module tb_dunc16_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  logic T0, T1, T2, T3, FETCH, EXECUTE, HALTED;

  dunc16_if bus ();

  dunc16_ctrl #(.ADDR_W(12)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .bus     (bus),
    .T0      (T0),
    .T1      (T1),
    .T2      (T2),
    .T3      (T3),
    .FETCH   (FETCH),
    .EXECUTE (EXECUTE),
    .HALTED  (HALTED)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Model: position 0..7 within an instruction (FETCH T0..T3, EXECUTE T0..T3).
  int m_pos;
  bit m_halt;

  // Result of the last run_instr.
  int r_cyc, r_wr, r_pc_ex, r_mdsel, r_md, r_alu, r_exs;
  logic [29:0] r_tseq;
  bit r_done;

  // {T0,T1,T2,T3,FETCH,EXECUTE,HALTED,EN_PC,EN_MA,EN_MD,EN_AC,EN_IR,
  //  SEL_PC,SEL_MA,SEL_MD,ALU_OP[1:0],MEM_RD,MEM_WR}
  function automatic logic [18:0] dut_vec();
    return {T0, T1, T2, T3, FETCH, EXECUTE, HALTED,
            bus.EN_PC, bus.EN_MA, bus.EN_MD, bus.EN_AC, bus.EN_IR,
            bus.SEL_PC, bus.SEL_MA, bus.SEL_MD, bus.ALU_OP, bus.MEM_RD, bus.MEM_WR};
  endfunction

  function automatic bit model_mem(int pos, logic [3:0] op);
    return (pos == 1) || (pos == 5 && (op == 4'h0 || op == 4'h2 || op == 4'h3)) ||
           (pos == 6 && op == 4'h1);
  endfunction

  function automatic logic [18:0] model_out(int pos, bit h, logic [3:0] op,
                                            logic an, logic az, logic rdy);
    logic [18:0] v;
    v = '0;
    if (h) begin
      v[12] = 1'b1;
      return v;
    end
    v[18 - (pos % 4)] = 1'b1;
    if (pos < 4) v[14] = 1'b1;
    else         v[13] = 1'b1;
    case (pos)
      0: v[10] = 1'b1;
      1: begin v[1] = 1'b1; v[9] = rdy; end
      2: begin v[7] = 1'b1; v[11] = 1'b1; end
      4: begin
        if (op <= 4'h3) begin v[10] = 1'b1; v[5] = 1'b1; end
        else if (op == 4'h4 || (op == 4'h5 && an) || (op == 4'h6 && az)) begin
          v[11] = 1'b1; v[6] = 1'b1;
        end
      end
      5: begin
        if (op == 4'h0 || op == 4'h2 || op == 4'h3) begin v[1] = 1'b1; v[9] = rdy; end
        else if (op == 4'h1) begin v[9] = 1'b1; v[4] = 1'b1; end
      end
      6: begin
        if (op == 4'h0) v[8] = 1'b1;
        else if (op == 4'h2) begin v[8] = 1'b1; v[3:2] = 2'b01; end
        else if (op == 4'h3) begin v[8] = 1'b1; v[3:2] = 2'b10; end
        else if (op == 4'h1) v[0] = 1'b1;
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (model pos %0d halt %0d)",
               name, act, exp, m_pos, m_halt);
    end
  endtask

  task automatic model_step();
    if (!RESET) begin
      m_pos  = 0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_pos == 4 && bus.IR == 4'hF) m_halt = 1'b1;
      else if (!(model_mem(m_pos, bus.IR) && !bus.MEM_RDY)) m_pos = (m_pos + 1) % 8;
    end
  endtask

  task automatic tick(output logic [18:0] snap);
    @(negedge CLK);
    snap = dut_vec();
    check("outs", {13'd0, snap},
          {13'd0, model_out(m_pos, m_halt, bus.IR, bus.AN, bus.AZ, bus.MEM_RDY)});
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic assert_reset();
    RESET  = 1'b0;
    m_pos  = 0;
    m_halt = 1'b0;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic an, input logic az,
                           input int fw, input int ew);
    logic [18:0] s;
    int fwl, ewl;
    fwl = fw; ewl = ew;
    bus.IR = op; bus.AN = an; bus.AZ = az;
    r_cyc = 0; r_wr = 0; r_pc_ex = 0; r_mdsel = 0; r_md = 0; r_alu = -1; r_exs = 0;
    r_tseq = '0; r_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (model_mem(m_pos, op)) begin
        if (m_pos == 1 && fwl > 0)      begin bus.MEM_RDY = 1'b0; fwl--; end
        else if (m_pos != 1 && ewl > 0) begin bus.MEM_RDY = 1'b0; ewl--; end
        else                                  bus.MEM_RDY = 1'b1;
      end else begin
        bus.MEM_RDY = 1'($urandom_range(0, 1));
      end
      tick(s);
      r_cyc++;
      if (r_cyc <= 5) r_tseq = {r_tseq[23:0], s[18:13]};
      if (s[0]) r_wr++;
      if (s[13] && s[11]) r_pc_ex++;
      if (s[9] && s[4]) r_mdsel++;
      if (s[9]) r_md++;
      if (s[8]) r_alu = int'(s[3:2]);
      if (s[13] && (|{s[11:7], s[1:0]})) r_exs++;
      if (m_pos == 0 || m_halt) begin
        r_done = 1'b1;
        break;
      end
    end
    check("instr_done", {31'd0, r_done}, 32'd1);
  endtask

  initial begin
    logic [18:0] s;
    RESET = 1'b0;
    bus.IR = 4'h0; bus.AN = 1'b0; bus.AZ = 1'b0; bus.MEM_RDY = 1'b0;
    m_pos = 0; m_halt = 1'b0;

    repeat (3) tick(s);
    check("reset_outs", {13'd0, s}, 32'h44400);
    RESET = 1'b1;

    run_instr(4'h0, 1'b0, 1'b0, 0, 0);
    check("lda_cycles", r_cyc, 8);
    check("first_states", {2'd0, r_tseq}, {2'd0, 30'b100010_010010_001010_000110_100001});
    check("lda_en_md", r_md, 2);
    check("lda_alu", r_alu, 0);

    run_instr(4'h1, 1'b0, 1'b0, 0, 2);
    check("sta_cycles", r_cyc, 10);
    check("sta_wr_len", r_wr, 3);
    check("sta_md_sel", r_mdsel, 1);

    run_instr(4'h2, 1'b0, 1'b0, 1, 1);
    check("add_cycles", r_cyc, 10);
    check("add_alu", r_alu, 1);

    run_instr(4'h3, 1'b0, 1'b0, 0, 0);
    check("and_cycles", r_cyc, 8);
    check("and_alu", r_alu, 2);

    run_instr(4'h4, 1'b0, 1'b0, 0, 0);
    check("jmp_pc", r_pc_ex, 1);
    run_instr(4'h5, 1'b1, 1'b0, 0, 0);
    check("ban_taken", r_pc_ex, 1);
    run_instr(4'h5, 1'b0, 1'b1, 0, 0);
    check("ban_not", r_pc_ex, 0);
    run_instr(4'h6, 1'b0, 1'b1, 0, 0);
    check("baz_taken", r_pc_ex, 1);
    run_instr(4'h6, 1'b1, 1'b0, 0, 0);
    check("baz_not", r_pc_ex, 0);

    run_instr(4'h9, 1'b1, 1'b1, 0, 0);
    check("nop_cycles", r_cyc, 8);
    check("nop_strobes", r_exs, 0);

    // Abort a stalled fetch read with an asynchronous reset.
    bus.IR = 4'h0; bus.MEM_RDY = 1'b0;
    tick(s);
    #2;
    check("rd_before_abort", {31'd0, bus.MEM_RD}, 32'd1);
    assert_reset();
    #1;
    check("rd_abort", {31'd0, bus.MEM_RD}, 32'd0);
    check("abort_state", {26'd0, T0, T1, T2, T3, FETCH, EXECUTE}, {26'd0, 6'b100010});
    tick(s);
    check("abort_reset_outs", {13'd0, s}, 32'h44400);
    RESET = 1'b1;
    run_instr(4'h0, 1'b0, 1'b0, 0, 0);
    check("lda_after_abort", r_cyc, 8);

    run_instr(4'hF, 1'b0, 1'b0, 0, 0);
    check("hlt_cycles", r_cyc, 5);
    for (int i = 0; i < 20; i++) begin
      bus.IR = 4'(i);
      bus.MEM_RDY = 1'($urandom_range(0, 1));
      tick(s);
      check("halt_hold", {13'd0, s}, 32'h01000);
    end
    assert_reset();
    #1;
    check("halt_reset_outs", {13'd0, dut_vec()}, 32'h44400);
    tick(s);
    RESET = 1'b1;
    run_instr(4'h2, 1'b0, 1'b0, 0, 0);
    check("add_after_halt", r_cyc, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
